// File: rtl/term_writer.sv
// term_writer: character-level terminal controller.
//
// Accepts received bytes over a valid/ready handshake and turns them into
// screen VRAM writes at a hardware cursor. Printable bytes (0x20..0x7E) are
// written at the cursor and advance it; CR, BS and LF move the cursor; LF and
// a line wrap clear the newly entered row; FF hands the whole screen over to
// the external screen-clear block and homes the cursor once it is done.
//
// Ports:
//   i_clk          system clock; state changes on the falling edge so VRAM,
//                  which samples on the rising edge, sees stable signals
//   i_rst          asynchronous active-high reset
//   i_data/i_valid received byte and its valid flag
//   o_ready        high only in IDLE; a byte is taken when i_valid & o_ready
//   o_clr_start    one-cycle start pulse to the screen-clear block
//   i_clr_running  busy flag from the screen-clear block
//   o_vram_addr    VRAM address {row, col}
//   o_vram_din     VRAM write data, {1'b0, char} or FILL
//   o_vram_w       VRAM write enable
//   o_vram_ce      VRAM chip enable, always equal to o_vram_w
//   o_cursor       cursor address {row, col} for the cursor overlay

module term_writer #(
  parameter logic [8:0] FILL     = 9'h000,
  parameter logic [5:0] LAST_COL = 6'd63,
  parameter logic [4:0] LAST_ROW = 5'd31
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_clr_start,
  input  logic        i_clr_running,
  output logic [10:0] o_vram_addr,
  output logic [8:0]  o_vram_din,
  output logic        o_vram_w,
  output logic        o_vram_ce,
  output logic [10:0] o_cursor
);

  // Reset state is StClrReq so the screen gets cleared at power-up.
  localparam logic [2:0] StClrReq    = 3'd0;
  localparam logic [2:0] StClrWaitHi = 3'd1;
  localparam logic [2:0] StClrWaitLo = 3'd2;
  localparam logic [2:0] StIdle      = 3'd3;
  localparam logic [2:0] StWrite     = 3'd4;
  localparam logic [2:0] StRowClr    = 3'd5;

  localparam logic [7:0] ChBs = 8'h08;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChFf = 8'h0C;
  localparam logic [7:0] ChCr = 8'h0D;

  logic [2:0] state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic [5:0] k_q, k_d;
  logic [7:0] data_q, data_d;
  logic       clr_start_q, clr_start_d;

  logic [4:0] row_inc;
  logic       printable;
  logic       vram_w;

  assign row_inc   = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign printable = (i_data >= 8'h20) && (i_data <= 8'h7E);

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    data_d      = data_q;
    clr_start_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_valid) begin
          data_d = i_data;
          if (printable) begin
            state_d = StWrite;
          end else begin
            case (i_data)
              ChCr: col_d = 6'd0;
              ChBs: begin
                if (col_q != 6'd0) col_d = col_q - 6'd1;
              end
              ChLf: begin
                row_d   = row_inc;
                k_d     = 6'd0;
                state_d = StRowClr;
              end
              ChFf: begin
                // Start pulse is registered: raise it together with entry to StClrReq.
                state_d     = StClrReq;
                clr_start_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      StWrite: begin
        if (col_q == LAST_COL) begin
          col_d   = 6'd0;
          row_d   = row_inc;
          k_d     = 6'd0;
          state_d = StRowClr;
        end else begin
          col_d   = col_q + 6'd1;
          state_d = StIdle;
        end
      end

      StRowClr: begin
        if (k_q == LAST_COL) begin
          k_d     = 6'd0;
          state_d = StIdle;
        end else begin
          k_d = k_q + 6'd1;
        end
      end

      StClrReq: state_d = StClrWaitHi;

      StClrWaitHi: begin
        if (i_clr_running) state_d = StClrWaitLo;
      end

      StClrWaitLo: begin
        if (!i_clr_running) begin
          row_d   = 5'd0;
          col_d   = 6'd0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d     = StClrReq;
        clr_start_d = 1'b1;
      end
    endcase
  end

  // State register on the falling edge; VRAM samples on the rising edge.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StClrReq;
      row_q       <= 5'd0;
      col_q       <= 6'd0;
      k_q         <= 6'd0;
      data_q      <= 8'd0;
      clr_start_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      data_q      <= data_d;
      clr_start_q <= clr_start_d;
    end
  end

  // VRAM port: only WRITE and ROWCLR drive it, so the clear block owns VRAM
  // whenever it is running.
  always_comb begin
    vram_w      = 1'b0;
    o_vram_addr = 11'd0;
    o_vram_din  = 9'd0;
    case (state_q)
      StWrite: begin
        vram_w      = 1'b1;
        o_vram_addr = {row_q, col_q};
        o_vram_din  = {1'b0, data_q};
      end
      StRowClr: begin
        vram_w      = 1'b1;
        o_vram_addr = {row_q, k_q};
        o_vram_din  = FILL;
      end
      default: ;
    endcase
  end

  assign o_vram_w    = vram_w;
  assign o_vram_ce   = vram_w;
  assign o_ready     = (state_q == StIdle);
  assign o_clr_start = clr_start_q;
  assign o_cursor    = {row_q, col_q};

endmodule

// File: tb/tb_term_writer.sv
// Directed testbench for term_writer with a behavioural screen-clear model
// and a log of every VRAM write seen on the rising edge.

module tb_term_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        clr_start;
  logic        running;
  logic [10:0] vram_addr;
  logic [8:0]  vram_din;
  logic        vram_w;
  logic        vram_ce;
  logic [10:0] cursor;

  int tests = 0;
  int fails = 0;

  term_writer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_data        (data),
    .i_valid       (valid),
    .o_ready       (ready),
    .o_clr_start   (clr_start),
    .i_clr_running (running),
    .o_vram_addr   (vram_addr),
    .o_vram_din    (vram_din),
    .o_vram_w      (vram_w),
    .o_vram_ce     (vram_ce),
    .o_cursor      (cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen-clear model: running goes high on a start pulse for run_len cycles.
  int run_len = 2048;
  int cnt = 0;
  initial running = 1'b0;
  always @(posedge clk) begin
    if (clr_start) begin
      running <= 1'b1;
      cnt     <= run_len;
    end else if (running) begin
      if (cnt == 1) running <= 1'b0;
      cnt <= cnt - 1;
    end
  end

  logic [10:0] log_a[$];
  logic [8:0]  log_d[$];
  int ce_err = 0;
  int busy_err = 0;
  always @(posedge clk) begin
    if (vram_w === 1'b1) begin
      log_a.push_back(vram_addr);
      log_d.push_back(vram_din);
    end
    if (vram_ce !== vram_w) ce_err++;
    if (running && vram_w === 1'b1) busy_err++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  // Called just after a rising edge; returns on the rising edge after the accept.
  task automatic send(input logic [7:0] b);
    int n = 0;
    data  = b;
    valid = 1'b1;
    while (ready !== 1'b1 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %02h not accepted, got ready=%b expected 1", b, ready);
    end
    @(posedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_ready(output int n, input int budget);
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(posedge clk);
      n++;
    end
  endtask

  // Count rising edges until ready, and start pulses seen along the way.
  task automatic wait_clear(output int n, output int starts, input int budget);
    n = 0;
    starts = 0;
    while (ready !== 1'b1 && n < budget) begin
      if (clr_start === 1'b1) starts++;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int starts;
    rst = 1'b1;
    valid = 1'b0;
    data = 8'h00;
    run_len = 2048;
    repeat (3) @(posedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b expected 0", ready); end
    tests++; if (vram_w !== 1'b0) begin fails++; $display("FAIL rst_w: got %b expected 0", vram_w); end
    tests++; if (vram_ce !== 1'b0) begin fails++; $display("FAIL rst_ce: got %b expected 0", vram_ce); end
    tests++; if (vram_addr !== 11'd0) begin fails++; $display("FAIL rst_addr: got %0h expected 0", vram_addr); end
    tests++; if (vram_din !== 9'd0) begin fails++; $display("FAIL rst_din: got %0h expected 0", vram_din); end
    tests++; if (cursor !== 11'd0) begin fails++; $display("FAIL rst_cursor: got %0h expected 0", cursor); end
    tests++; if (clr_start !== 1'b1) begin fails++; $display("FAIL rst_clr_start: got %b expected 1", clr_start); end
    rst = 1'b0;
    wait_clear(n, starts, 5000);
    tests++; if (starts != 1) begin fails++; $display("FAIL rst_start_pulse: got %0d cycles expected 1", starts); end
    tests++; if (n != 2049) begin fails++; $display("FAIL rst_busy_len: got %0d expected 2049", n); end
    tests++; if (cursor !== 11'd0) begin fails++; $display("FAIL rst_home: got %0h expected 0", cursor); end
  endtask

  task automatic test_print_ab();
    int n;
    clear_log();
    send(8'h41);
    tests++; if (vram_ce !== 1'b1) begin fails++; $display("FAIL ab_ce: got %b expected 1", vram_ce); end
    send(8'h42);
    wait_ready(n, 20);
    tests++; if (log_a.size() != 2) begin fails++; $display("FAIL ab_count: got %0d expected 2", log_a.size()); end
    if (log_a.size() >= 2) begin
      tests++; if (log_a[0] !== 11'd0) begin fails++; $display("FAIL ab_addr0: got %0h expected 0", log_a[0]); end
      tests++; if (log_d[0] !== 9'h041) begin fails++; $display("FAIL ab_din0: got %0h expected 041", log_d[0]); end
      tests++; if (log_a[1] !== 11'd1) begin fails++; $display("FAIL ab_addr1: got %0h expected 1", log_a[1]); end
      tests++; if (log_d[1] !== 9'h042) begin fails++; $display("FAIL ab_din1: got %0h expected 042", log_d[1]); end
    end
    tests++; if (cursor !== 11'd2) begin fails++; $display("FAIL ab_cursor: got %0h expected 2", cursor); end
  endtask

  task automatic test_line_wrap();
    int n;
    int bad;
    logic [7:0] b;
    send(8'h0D);
    tests++; if (cursor !== 11'd0) begin fails++; $display("FAIL wrap_cr: got %0h expected 0", cursor); end
    for (int i = 0; i < 63; i++) begin
      b = 8'h30 + 8'(i % 10);
      send(b);
    end
    wait_ready(n, 20);
    tests++; if (cursor !== 11'd63) begin fails++; $display("FAIL wrap_pre_cursor: got %0h expected 3f", cursor); end
    clear_log();
    send(8'h5A);
    wait_ready(n, 200);
    tests++; if (n != 65) begin fails++; $display("FAIL wrap_busy_len: got %0d expected 65", n); end
    tests++; if (log_a.size() != 65) begin fails++; $display("FAIL wrap_count: got %0d expected 65", log_a.size()); end
    if (log_a.size() == 65) begin
      tests++; if (log_a[0] !== 11'd63) begin fails++; $display("FAIL wrap_z_addr: got %0h expected 3f", log_a[0]); end
      tests++; if (log_d[0] !== 9'h05A) begin fails++; $display("FAIL wrap_z_din: got %0h expected 05a", log_d[0]); end
      bad = 0;
      for (int i = 1; i < 65; i++) begin
        if (log_a[i] !== 11'(63 + i) || log_d[i] !== 9'h000) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL wrap_fill: got %0d bad entries expected 0", bad); end
    end
    tests++; if (cursor !== 11'd64) begin fails++; $display("FAIL wrap_cursor: got %0h expected 40", cursor); end
  endtask

  task automatic test_lf_wrap();
    int n;
    int bad;
    for (int i = 0; i < 30; i++) begin
      send(8'h0A);
      wait_ready(n, 200);
    end
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h2E);
    wait_ready(n, 20);
    tests++; if (cursor !== 11'h7C5) begin fails++; $display("FAIL lf_pre_cursor: got %0h expected 7c5", cursor); end
    clear_log();
    send(8'h0A);
    wait_ready(n, 200);
    tests++; if (n != 64) begin fails++; $display("FAIL lf_busy_len: got %0d expected 64", n); end
    tests++; if (log_a.size() != 64) begin fails++; $display("FAIL lf_count: got %0d expected 64", log_a.size()); end
    if (log_a.size() == 64) begin
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        if (log_a[i] !== 11'(i) || log_d[i] !== 9'h000) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL lf_fill: got %0d bad entries expected 0", bad); end
    end
    tests++; if (cursor !== 11'd5) begin fails++; $display("FAIL lf_cursor: got %0h expected 5", cursor); end
  endtask

  // A byte offered during ROWCLR must wait and be written exactly once.
  task automatic test_hold();
    int n;
    clear_log();
    send(8'h0A);
    send(8'h51);
    wait_ready(n, 20);
    tests++; if (log_a.size() != 65) begin fails++; $display("FAIL hold_count: got %0d expected 65", log_a.size()); end
    if (log_a.size() == 65) begin
      tests++; if (log_a[64] !== 11'd69) begin fails++; $display("FAIL hold_addr: got %0h expected 45", log_a[64]); end
      tests++; if (log_d[64] !== 9'h051) begin fails++; $display("FAIL hold_din: got %0h expected 051", log_d[64]); end
    end
    tests++; if (cursor !== 11'd70) begin fails++; $display("FAIL hold_cursor: got %0h expected 46", cursor); end
  endtask

  task automatic test_back_to_back();
    int n;
    send(8'h0D);
    tests++; if (cursor !== 11'd64) begin fails++; $display("FAIL b2b_cr0: got %0h expected 40", cursor); end
    send(8'h08);
    tests++; if (cursor !== 11'd64) begin fails++; $display("FAIL b2b_bs_col0: got %0h expected 40", cursor); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0: got %b expected 1", ready); end
    for (int i = 0; i < 18; i++) send(8'h61);
    wait_ready(n, 20);
    tests++; if (cursor !== 11'd82) begin fails++; $display("FAIL b2b_pre: got %0h expected 52", cursor); end
    clear_log();
    send(8'h08);
    tests++; if (cursor !== 11'd81) begin fails++; $display("FAIL b2b_bs: got %0h expected 51", cursor); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1: got %b expected 1", ready); end
    send(8'h0D);
    tests++; if (cursor !== 11'd64) begin fails++; $display("FAIL b2b_cr17: got %0h expected 40", cursor); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready2: got %b expected 1", ready); end
    send(8'h7F);
    tests++; if (cursor !== 11'd64) begin fails++; $display("FAIL b2b_del: got %0h expected 40", cursor); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready3: got %b expected 1", ready); end
    @(posedge clk);
    tests++; if (log_a.size() != 0) begin fails++; $display("FAIL b2b_no_write: got %0d writes expected 0", log_a.size()); end
  endtask

  task automatic test_ff();
    int n;
    int starts;
    run_len = 10;
    clear_log();
    send(8'h0C);
    wait_clear(n, starts, 500);
    tests++; if (starts != 1) begin fails++; $display("FAIL ff_start_pulse: got %0d cycles expected 1", starts); end
    tests++; if (n != 11) begin fails++; $display("FAIL ff_busy_len: got %0d expected 11", n); end
    tests++; if (cursor !== 11'd0) begin fails++; $display("FAIL ff_cursor: got %0h expected 0", cursor); end
    tests++; if (log_a.size() != 0) begin fails++; $display("FAIL ff_no_write: got %0d writes expected 0", log_a.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    int starts;
    send(8'h0A);
    repeat (5) @(posedge clk);
    tests++; if (vram_w !== 1'b1) begin fails++; $display("FAIL mid_rowclr_w: got %b expected 1", vram_w); end
    rst = 1'b1;
    #1;
    tests++; if (vram_w !== 1'b0) begin fails++; $display("FAIL mid_w: got %b expected 0", vram_w); end
    tests++; if (vram_ce !== 1'b0) begin fails++; $display("FAIL mid_ce: got %b expected 0", vram_ce); end
    tests++; if (cursor !== 11'd0) begin fails++; $display("FAIL mid_cursor: got %0h expected 0", cursor); end
    tests++; if (clr_start !== 1'b1) begin fails++; $display("FAIL mid_clr_start: got %b expected 1", clr_start); end
    run_len = 16;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    wait_clear(n, starts, 500);
    tests++; if (starts != 1) begin fails++; $display("FAIL mid_start_pulse: got %0d cycles expected 1", starts); end
    tests++; if (n != 17) begin fails++; $display("FAIL mid_busy_len: got %0d expected 17", n); end
    tests++; if (cursor !== 11'd0) begin fails++; $display("FAIL mid_home: got %0h expected 0", cursor); end
  endtask

  task automatic test_enables();
    tests++; if (ce_err != 0) begin fails++; $display("FAIL ce_eq_w: got %0d mismatching cycles expected 0", ce_err); end
    tests++; if (busy_err != 0) begin fails++; $display("FAIL vram_while_busy: got %0d cycles expected 0", busy_err); end
  endtask

  initial begin
    test_reset();
    test_print_ab();
    test_line_wrap();
    test_lf_wrap();
    test_hold();
    test_back_to_back();
    test_ff();
    test_reset_mid();
    test_enables();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/term_writer.md
# term_writer

Character-level terminal controller for the serial terminal. It consumes received bytes from the UART receiver through a valid/ready handshake and writes printable characters into screen VRAM at a hardware cursor. It handles CR, LF, BS and FF, and clears rows itself on line advance. For full-screen clears it delegates to the screen-clear block through a start/running handshake; the top level multiplexes VRAM between the two blocks using `i_clr_running`.

## Interface
Parameters:
- `FILL`, 9'h000, word written to VRAM when clearing a row.
- `LAST_COL`, 6'd63, last column index; also the column counter wrap point.
- `LAST_ROW`, 5'd31, last row index; also the row counter wrap point.

Ports:
- `i_clk` in 1: system clock. All state updates on the falling edge, because VRAM samples on the rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_data` in 8: received byte.
- `i_valid` in 1: `i_data` is valid.
- `o_ready` out 1: block accepts a byte this cycle.
- `o_clr_start` out 1: one-cycle start pulse to the screen-clear block.
- `i_clr_running` in 1: busy flag from the screen-clear block.
- `o_vram_addr` out 11: VRAM address, `{row[4:0], col[5:0]}`.
- `o_vram_din` out 9: VRAM write data, `{1'b0, char}` or `FILL`.
- `o_vram_w` out 1: VRAM write enable.
- `o_vram_ce` out 1: VRAM chip enable, always equal to `o_vram_w`.
- `o_cursor` out 11: cursor address `{row, col}`, used by the cursor overlay.

## Operation
- States: CLR_REQ, CLR_WAIT_HI, CLR_WAIT_LO, IDLE, WRITE, ROWCLR.
- `o_ready` = 1 only in IDLE. A byte is accepted on the edge where `i_valid & o_ready`. The accepted byte is latched.
- On accept, decode the byte:
  - 0x20–0x7E (printable): go to WRITE.
  - 0x0D (CR): col ← 0. Stay in IDLE.
  - 0x08 (BS): if col > 0, col ← col−1; if col = 0, no change. No erase. Stay in IDLE.
  - 0x0A (LF): row ← row+1, wrapping LAST_ROW → 0; col unchanged. Go to ROWCLR.
  - 0x0C (FF): go to CLR_REQ.
  - Any other byte: discarded. Stay in IDLE.
- WRITE (1 cycle):
  - Outputs: `o_vram_w` = `o_vram_ce` = 1, `o_vram_addr` = cursor, `o_vram_din` = `{1'b0, byte}`.
  - Then col ← col+1 and go to IDLE.
  - If col = LAST_COL instead: col ← 0, row ← row+1 (wrapping), and go to ROWCLR.
- ROWCLR (LAST_COL+1 cycles):
  - Internal counter k runs 0..LAST_COL. Outputs: `o_vram_addr` = `{row, k}`, `o_vram_din` = `FILL`, write and chip enable = 1.
  - Go to IDLE after k = LAST_COL. Cursor is not changed.
- CLR_REQ (1 cycle): `o_clr_start` = 1. Then go to CLR_WAIT_HI.
- CLR_WAIT_HI: wait for `i_clr_running` = 1, then go to CLR_WAIT_LO.
- CLR_WAIT_LO: wait for `i_clr_running` = 0. Then cursor ← 0 and go to IDLE.
- `o_vram_w` = `o_vram_ce` = 0 in every state except WRITE and ROWCLR. The block never drives VRAM while the clear block is running.
- Widths: row 5 bits and col 6 bits, both wrapping modulo (LAST+1). The VRAM address is the plain concatenation; there is no arithmetic across the field boundary.

## Timing
- Reset (asynchronous, on assertion):
  - State = CLR_REQ, cursor = 0, k = 0.
  - `o_ready` = 0, `o_vram_w` = `o_vram_ce` = 0, `o_vram_addr` = 0, `o_vram_din` = 0.
  - `o_clr_start` = 1 while in CLR_REQ, so the screen is cleared at power-up.
- Reset mid-operation (any state): the same values apply. An in-progress clear is restarted by the new start pulse.
- Printable byte accepted at edge N:
  - VRAM write is active during cycle N+1.
  - `o_ready` = 1 again in cycle N+2.
  - `o_cursor` updates at edge N+1.
- CR, BS and ignored bytes: cursor updates at the accept edge. `o_ready` stays 1, giving one byte per cycle.
- LF: `o_ready` is 0 for exactly LAST_COL+1 cycles (64 by default).
- Line wrap by printable: 1 write cycle plus 64 clear cycles, so `o_ready` = 0 for 65 cycles.
- FF: `o_ready` is 0 from the accept until one cycle after `i_clr_running` falls.
- `o_clr_start` is registered and is never high for more than 1 cycle per request.
- A byte presented while `o_ready` = 0 is held by the source. It is not dropped and is not accepted early.

## Test plan
- Release reset with a clear-block model whose running flag is high for 2048 cycles. Require: `o_clr_start` high exactly 1 cycle; `o_ready` = 0 until 1 cycle after running falls; then `o_cursor` = 0 and `o_ready` = 1.
- Send 'A' (0x41), then 'B' (0x42). Require: writes `{addr 0, din 9'h041}` then `{addr 1, din 9'h042}`; `o_cursor` = 2.
- Send 63 printables, then 'Z' (0x5A) from cursor 0. Require: 'Z' written at addr 63; then 64 writes of `FILL` at addr 64..127; `o_cursor` = 64.
- With cursor = `{31, 5}`, send LF. Require: row wraps to 0; addr 0..63 receive `FILL`; cursor = `{0, 5}`; `o_ready` low for 64 cycles.
- Handle BS at col 0 (cursor unchanged), then CR at col 17 (col → 0), then byte 0x7F (ignored, no VRAM write), all accepted back-to-back with `o_ready` held at 1.
- Assert `i_rst` in the middle of ROWCLR. Require: VRAM enables drop immediately; cursor = 0; a new `o_clr_start` pulse follows after reset release.
